// File: rtl/counter_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
// Provides the slice width and the IDLE/RUN/DONE state type.
package counter_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder slice.
// Ports: a, b (4b), cin in; s (4b), cout out.
module nibble_add4
  import counter_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] t;

  assign t    = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
  assign s    = t[NIB_W-1:0];
  assign cout = t[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder: WIDTH-bit operands summed one nibble per clock
// through a single 4-bit slice, LS nibble first, result on valid/ready.
// Ports: clk, rst_n; in_valid/in_ready, in_a, in_b, in_cin;
//        out_valid/out_ready, out_sum, out_cout, out_ovf; busy.
module nibble_serial_adder
  import counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB_W-1:0] a_nib, b_nib, s_nib;
  logic             c_nib;

  assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
  assign b_nib = b_q[idx_q*NIB_W +: NIB_W];

  nibble_add4 u_add4 (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = s_nib;
        carry_d = c_nib;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          cout_d  = c_nib;
          // slice sum MSB is the result MSB on the last nibble
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (s_nib[NIB_W-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
